// File: rtl/bus_interface_unit.sv
// bus_interface_unit: 6502 pin-level bus sequencer (address bytes on uo_out, data on uio).
// Optional `BIU_TIMEOUT_EN aborts a DATA phase after TIMEOUT_CYCLES wait cycles and pulses err.
`timescale 1ns/1ps
module bus_interface_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        err,
    output logic [7:0]  addr_out,
    output logic [1:0]  phase,
    output logic        rw_out,
    input  logic        ext_rdy,
    input  logic [7:0]  uio_in,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    // State encoding doubles as the phase output.
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ADDR_LO = 2'b01,
        S_ADDR_HI = 2'b10,
        S_DATA    = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        drive_data;

`ifdef BIU_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
`ifdef BIU_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
`ifdef BIU_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
`ifdef BIU_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = S_ADDR_LO;
                end
            end
            S_ADDR_LO: state_d = S_ADDR_HI;
            S_ADDR_HI: begin
                state_d = S_DATA;
`ifdef BIU_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_DATA: begin
                if (ext_rdy) begin
                    if (!we_q) rdata_d = uio_in;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
`ifdef BIU_TIMEOUT_EN
                // This wait cycle is the limit-th one: abort instead of counting further.
                else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    if (!we_q) rdata_d = 8'hFF;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_out = '0;
        unique case (state_q)
            S_ADDR_LO:        addr_out = addr_q[7:0];
            S_ADDR_HI, S_DATA: addr_out = addr_q[15:8];
            default:          addr_out = '0;
        endcase
    end

    assign drive_data = (state_q == S_DATA) && we_q;
    assign busy       = (state_q != S_IDLE);
    assign phase      = state_q;
    assign rw_out     = busy & we_q;
    assign uio_oe     = {8{drive_data}};
    assign uio_out    = drive_data ? wdata_q : '0;
    assign rdata      = rdata_q;
    assign done       = done_q;
`ifdef BIU_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_bus_interface_unit.sv
// Self-checking bench for bus_interface_unit: transaction-level expected traces, random traffic.
`timescale 1ns/1ps
module tb_bus_interface_unit;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        ext_rdy = 1'b0;
    logic [7:0]  uio_in = '0;
    logic        busy, done, err, rw_out;
    logic [7:0]  rdata, addr_out, uio_out, uio_oe;
    logic [1:0]  phase;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_rdata = '0;

    always #5 clk = ~clk;

    bus_interface_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .err(err), .addr_out(addr_out),
        .phase(phase), .rw_out(rw_out), .ext_rdy(ext_rdy), .uio_in(uio_in),
        .uio_out(uio_out), .uio_oe(uio_oe)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag, input bit exp_done, input bit exp_err);
        check({tag, ".busy"},   16'(busy),     16'(0));
        check({tag, ".done"},   16'(done),     16'(exp_done));
        check({tag, ".err"},    16'(err),      16'(exp_err));
        check({tag, ".phase"},  16'(phase),    16'(0));
        check({tag, ".addr"},   16'(addr_out), 16'(0));
        check({tag, ".rw"},     16'(rw_out),   16'(0));
        check({tag, ".oe"},     16'(uio_oe),   16'(0));
        check({tag, ".rdata"},  16'(rdata),    16'(exp_rdata));
    endtask

    task automatic check_busy(input string tag, input logic [1:0] ph, input logic [7:0] ab, input bit w,
                              input logic [7:0] d);
        check({tag, ".busy"},  16'(busy),     16'(1));
        check({tag, ".done"},  16'(done),     16'(0));
        check({tag, ".err"},   16'(err),      16'(0));
        check({tag, ".phase"}, 16'(phase),    16'(ph));
        check({tag, ".addr"},  16'(addr_out), 16'(ab));
        check({tag, ".rw"},    16'(rw_out),   16'(w));
        check({tag, ".oe"},    16'(uio_oe),   (ph == 2'b11 && w) ? 16'hFF : 16'h00);
        if (ph == 2'b11 && w) check({tag, ".wd"}, 16'(uio_out), 16'(d));
        check({tag, ".rdata"}, 16'(rdata),    16'(exp_rdata));
    endtask

    // Called at a negedge with the DUT idle or in its done cycle; returns in the done cycle.
    task automatic xfer(input bit w, input logic [15:0] a, input logic [7:0] d,
                        input int unsigned waits, input logic [7:0] rd, input bit noise);
        int unsigned ndata;
        bit          abort;
        abort = 1'b0;
        ndata = waits + 1;
`ifdef BIU_TIMEOUT_EN
        if (waits >= TO) begin
            abort = 1'b1;
            ndata = TO;
        end
`endif
        req = 1'b1; we = w; addr = a; wdata = d;
        ext_rdy = 1'($urandom); uio_in = 8'($urandom);
        @(negedge clk);
        req = noise ? 1'($urandom) : 1'b0;
        we = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
        check_busy("alo", 2'b01, a[7:0], w, d);
        @(negedge clk);
        req = noise ? 1'($urandom) : 1'b0;
        check_busy("ahi", 2'b10, a[15:8], w, d);
        for (int unsigned i = 0; i < ndata; i++) begin
            @(negedge clk);
            check_busy("data", 2'b11, a[15:8], w, d);
            ext_rdy = !abort && (i == ndata - 1);
            uio_in  = ext_rdy ? rd : 8'($urandom);
            req     = noise ? 1'($urandom) : 1'b0;
        end
        @(negedge clk);
        if (!w) exp_rdata = abort ? 8'hFF : rd;
        check_idle("done", 1'b1, abort);
        req = 1'b0;
        ext_rdy = 1'($urandom);
    endtask

    task automatic idle_cycles(input int unsigned n);
        req = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            ext_rdy = 1'($urandom);
            check_idle("idle", 1'b0, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check_idle("rst", 1'b0, 1'b0);
        check("rst.uio_out", 16'(uio_out), 16'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        xfer(1'b0, 16'hBEEF, 8'h00, 0, 8'h5A, 1'b0);
        idle_cycles(1);
        xfer(1'b1, 16'h1234, 8'hC3, 0, 8'h00, 1'b0);
        idle_cycles(1);
        xfer(1'b0, 16'h4000, 8'h00, 3, 8'h77, 1'b0);
        idle_cycles(1);
        xfer(1'b0, 16'h0002, 8'h00, 0, 8'h11, 1'b1);
        xfer(1'b0, 16'h0001, 8'h00, 0, 8'h22, 1'b1);
        idle_cycles(2);
        xfer(1'b0, 16'hCAFE, 8'h00, TO + 3, 8'h99, 1'b1);
        xfer(1'b0, 16'h8001, 8'h00, TO - 1, 8'h3C, 1'b0);
        xfer(1'b1, 16'h8002, 8'hA7, TO, 8'h00, 1'b0);
        xfer(1'b0, 16'h8003, 8'h00, TO, 8'h44, 1'b0);
        idle_cycles(1);

        for (int n = 0; n < 40; n++) begin
            int unsigned wt;
            wt = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(0, 5);
            xfer(1'($urandom), 16'($urandom), 8'($urandom), wt, 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end
        xfer(1'b0, 16'h00F0, 8'h00, 0, 8'hE1, 1'b0);

        // Asynchronous reset during ADDR_HI.
        req = 1'b1; we = 1'b0; addr = 16'hA5A5; wdata = 8'h00;
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_rdata = 8'h00;
        check_idle("arst", 1'b0, 1'b0);
        check("arst.uio_out", 16'(uio_out), 16'(0));
        @(negedge clk);
        check_idle("arst_hold", 1'b0, 1'b0);
        rst_n = 1'b1;
        idle_cycles(3);
        xfer(1'b0, 16'h2468, 8'h00, 1, 8'hB6, 1'b0);
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
